// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 field widths, constants, FSM states and pipeline payloads
// shared by the sequential fp32 subtractor.
package fp32_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned EXT_W  = SIG_W + 3;   // significand plus guard/round/sticky
    localparam int unsigned RND_W  = SIG_W + 1;
    localparam int unsigned NX_W   = EXP_W + 2;   // exponent with overflow headroom
    localparam int unsigned LZC_W  = 5;

    localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
    localparam logic [DATA_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [DATA_W-1:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
    } special_t;

    typedef struct packed {
        logic [EXT_W-1:0] big_m;
        logic [EXT_W-1:0] sml_m;
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic             sub;
        special_t         special;
    } align_t;

    typedef struct packed {
        logic [EXT_W:0]   sum;
        logic [EXP_W-1:0] exp;
        logic             sign;
        special_t         special;
    } sum_t;

    function automatic logic is_nan(input logic [DATA_W-1:0] x);
        return (x[DATA_W-2:MAN_W] == EXP_MAX) && (x[MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [DATA_W-1:0] x);
        return (x[DATA_W-2:MAN_W] == EXP_MAX) && (x[MAN_W-1:0] == '0);
    endfunction

    // Subnormals use exponent 1 with a zero hidden bit.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [DATA_W-1:0] x);
        return (x[DATA_W-2:MAN_W] == '0) ? EXP_W'(1) : x[DATA_W-2:MAN_W];
    endfunction

    function automatic logic [EXT_W-1:0] ext_sig(input logic [DATA_W-1:0] x);
        return {(x[DATA_W-2:MAN_W] != '0), x[MAN_W-1:0], 3'b000};
    endfunction
endpackage

// File: rtl/fp32_sub_lzc.sv
// fp32_sub_lzc: combinational leading-zero count over the extended significand.
module fp32_sub_lzc
    import fp32_pkg::*;
(
    input  logic [EXT_W-1:0] vec,
    output logic [LZC_W-1:0] count_c
);
    always_comb begin
        count_c = LZC_W'(EXT_W);
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (vec[i]) count_c = LZC_W'(int'(EXT_W) - 1 - i);
        end
    end
endmodule

// File: rtl/fp32_subtractor_seq.sv
// fp32_subtractor_seq: 4-cycle binary32 subtractor (out = a - b), valid/ready both sides.
// Define FP32_SUB_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp32_subtractor_seq
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    state_t state, state_next;
    logic   in_ready_d, out_valid_d;

    logic [DATA_W-1:0] op_a, op_b;
    align_t            align_d, align_q;
    sum_t              sum_d, sum_q;

    logic              a_big;
    logic [DATA_W-1:0] big_op, sml_op;
    logic [EXP_W-1:0]  big_exp, diff;
    logic [EXT_W-1:0]  sml_sig, shifted;
`ifdef FP32_SUB_ROUND_NEAREST_EN
    logic              sticky;
`endif

    logic [LZC_W-1:0]  lz, shamt;
    logic [EXT_W-1:0]  norm_m;
    logic [NX_W-1:0]   norm_exp, fin_exp;
    logic              rnd_inc, res_zero;
    logic [RND_W-1:0]  rnd_sig;
    logic [SIG_W-1:0]  fin_sig;
    logic [EXP_W-1:0]  exp_field;
    logic [DATA_W-1:0] result_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ALIGN;
            ALIGN:   state_next = ADDSUB;
            ADDSUB:  state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        in_ready_d  = (state_next == IDLE);
        out_valid_d = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            if (state == NORM) out_data <= result_c;
        end
    end

    // ALIGN: order by magnitude, resolve specials, shift the smaller significand
    always_comb begin
        a_big   = (op_a[DATA_W-2:0] >= op_b[DATA_W-2:0]);
        big_op  = a_big ? op_a : op_b;
        sml_op  = a_big ? op_b : op_a;
        big_exp = eff_exp(big_op);
        diff    = big_exp - eff_exp(sml_op);
        sml_sig = ext_sig(sml_op);
        shifted = (diff >= EXP_W'(EXT_W)) ? '0 : (sml_sig >> diff);

        align_d       = '0;
        align_d.big_m = ext_sig(big_op);
        align_d.exp   = big_exp;
        align_d.sign  = a_big ? op_a[DATA_W-1] : ~op_b[DATA_W-1];
        align_d.sub   = (op_a[DATA_W-1] == op_b[DATA_W-1]);
`ifdef FP32_SUB_ROUND_NEAREST_EN
        if (diff >= EXP_W'(EXT_W)) sticky = |sml_sig;
        else                       sticky = |(sml_sig & ~({EXT_W{1'b1}} << diff));
        align_d.sml_m = {shifted[EXT_W-1:1], shifted[0] | sticky};
`else
        align_d.sml_m = shifted & {{SIG_W{1'b1}}, {(EXT_W-SIG_W){1'b0}}};
`endif
        if (is_nan(op_a) || is_nan(op_b) ||
            (is_inf(op_a) && is_inf(op_b) && (op_a[DATA_W-1] == op_b[DATA_W-1])))
            align_d.special = '{valid: 1'b1, value: QNAN};
        else if (is_inf(op_a))
            align_d.special = '{valid: 1'b1, value: op_a};
        else if (is_inf(op_b))
            align_d.special = '{valid: 1'b1, value: {~op_b[DATA_W-1], op_b[DATA_W-2:0]}};
    end

    // ADDSUB: magnitude add or big-minus-small, never negative
    always_comb begin
        sum_d.sum     = align_q.sub ? ({1'b0, align_q.big_m} - {1'b0, align_q.sml_m})
                                    : ({1'b0, align_q.big_m} + {1'b0, align_q.sml_m});
        sum_d.exp     = align_q.exp;
        sum_d.sign    = align_q.sign;
        sum_d.special = align_q.special;
    end

    fp32_sub_lzc u_lzc (
        .vec     (sum_q.sum[EXT_W-1:0]),
        .count_c (lz)
    );

    // NORM: normalise (left shift clamped at exponent 1), round, pack
    always_comb begin
        shamt = '0;
        if (sum_q.sum[EXT_W]) begin
            norm_m   = {sum_q.sum[EXT_W:2], sum_q.sum[1] | sum_q.sum[0]};
            norm_exp = NX_W'(sum_q.exp) + NX_W'(1);
        end else begin
            if (EXP_W'(lz) >= sum_q.exp) shamt = LZC_W'(sum_q.exp - EXP_W'(1));
            else                         shamt = lz;
            norm_m   = sum_q.sum[EXT_W-1:0] << shamt;
            norm_exp = NX_W'(sum_q.exp) - NX_W'(shamt);
        end
`ifdef FP32_SUB_ROUND_NEAREST_EN
        rnd_inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
`else
        rnd_inc = 1'b0;
`endif
        rnd_sig  = {1'b0, norm_m[EXT_W-1:3]} + RND_W'(rnd_inc);
        res_zero = ~|norm_m;
        if (rnd_sig[SIG_W]) begin
            fin_sig = rnd_sig[SIG_W:1];
            fin_exp = norm_exp + NX_W'(1);
        end else begin
            fin_sig = rnd_sig[SIG_W-1:0];
            fin_exp = norm_exp;
        end
        exp_field = fin_sig[MAN_W] ? fin_exp[EXP_W-1:0] : '0;

        if (sum_q.special.valid)           result_c = sum_q.special.value;
        else if (res_zero)                 result_c = '0;
        else if (fin_exp >= NX_W'(EXP_MAX)) result_c = {sum_q.sign, POS_INF[DATA_W-2:0]};
        else                               result_c = {sum_q.sign, exp_field, fin_sig[MAN_W-1:0]};
    end

    // Datapath stage registers; an op dropped by reset is simply never read
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_a <= a;
            op_b <= b;
        end
        if (state == ALIGN)  align_q <= align_d;
        if (state == ADDSUB) sum_q   <= sum_d;
    end
endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// Bench for fp32_subtractor_seq: directed vectors plus random operands against an
// exact-integer reference model (rounding mode follows FP32_SUB_ROUND_NEAREST_EN).
module tb_fp32_subtractor_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fp32_subtractor_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic int exp_of(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    endfunction

    function automatic logic [63:0] sig_of(input logic [31:0] x);
        return {40'd0, (x[30:23] != 8'd0), x[22:0]};
    endfunction

    // Exact difference as an integer scaled by 2^(e_r-150), then rounded once.
    function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] yn;
        logic        sg, eff_sub, x_nan, y_nan, x_inf, y_inf;
        int          e_big, e_sml, d, e_r, p, e_top, e_u, s;
        logic [63:0] m_big, m_sml, r, q;
`ifdef FP32_SUB_ROUND_NEAREST_EN
        logic [63:0] rem, half;
`endif
        yn    = {~y[31], y[30:0]};
        x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (x_nan || y_nan) return 32'h7FC00000;
        if (x_inf && y_inf && (x[31] == y[31])) return 32'h7FC00000;
        if (x_inf) return x;
        if (y_inf) return yn;
        eff_sub = (x[31] != yn[31]);
        if (x[30:0] >= y[30:0]) begin
            sg = x[31]; e_big = exp_of(x); m_big = sig_of(x); e_sml = exp_of(y); m_sml = sig_of(y);
        end else begin
            sg = yn[31]; e_big = exp_of(y); m_big = sig_of(y); e_sml = exp_of(x); m_sml = sig_of(x);
        end
        d = e_big - e_sml;
`ifdef FP32_SUB_ROUND_NEAREST_EN
        // Far below half an ulp only its non-zeroness matters.
        if (d > 30) begin
            m_sml = (m_sml != 0) ? 64'd1 : 64'd0;
            d = 30;
        end
        r   = eff_sub ? ((m_big << d) - m_sml) : ((m_big << d) + m_sml);
        e_r = e_big - d;
`else
        m_sml = (d >= 24) ? 64'd0 : (m_sml >> d);
        r     = eff_sub ? (m_big - m_sml) : (m_big + m_sml);
        e_r   = e_big;
`endif
        if (r == 0) return 32'h00000000;
        p = 63;
        while (p > 0 && r[p] == 1'b0) p--;
        e_top = p + e_r - 23;
        e_u   = (e_top < 1) ? 1 : e_top;
        s     = e_u - e_r;
        if (s <= 0) begin
            q = r << (-s);
        end else begin
            q = r >> s;
`ifdef FP32_SUB_ROUND_NEAREST_EN
            rem  = r & ((64'd1 << s) - 64'd1);
            half = 64'd1 << (s - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
`endif
        end
        if (q == (64'd1 << 24)) begin
            q   = 64'd1 << 23;
            e_u = e_u + 1;
        end
        if (e_u >= 255) return {sg, 31'h7F800000};
        return {sg, q[23] ? 8'(e_u) : 8'd0, q[22:0]};
    endfunction

    task automatic rand_pair(output logic [31:0] x, output logic [31:0] y);
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: y[30:23] = x[30:23] + 8'($urandom_range(0, 3));
            2: y[30:0]  = x[30:0] ^ 31'($urandom_range(0, 255));
            default: begin
                x[30:23] = 8'($urandom_range(0, 2));
                y[30:23] = 8'($urandom_range(0, 2));
            end
        endcase
    endtask

    // Drives one operation (called in IDLE, #1 after an edge); lat counts the accept edge as 1.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output logic ok);
        int n;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        ok  = out_valid;
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[11], vb[11], ve[11], res;
        int          lat;
        logic        ok;
        va[0] = 32'h40400000; vb[0] = 32'h3F800000; ve[0] = 32'h40000000;
        va[1] = 32'h3F800000; vb[1] = 32'h3F800000; ve[1] = 32'h00000000;
        va[2] = 32'h3F800000; vb[2] = 32'hBF800000; ve[2] = 32'h40000000;
`ifdef FP32_SUB_ROUND_NEAREST_EN
        va[3] = 32'h3F800000; vb[3] = 32'h33800000; ve[3] = 32'h3F7FFFFF;
`else
        va[3] = 32'h3F800000; vb[3] = 32'h33800000; ve[3] = 32'h3F800000;
`endif
        va[4] = 32'h7F800000; vb[4] = 32'h7F800000; ve[4] = 32'h7FC00000;
        va[5] = 32'h7F7FFFFF; vb[5] = 32'hFF7FFFFF; ve[5] = 32'h7F800000;
        va[6] = 32'h7FC12345; vb[6] = 32'h3F800000; ve[6] = 32'h7FC00000;
        va[7] = 32'h3F800000; vb[7] = 32'h7F800000; ve[7] = 32'hFF800000;
        va[8] = 32'hFF800000; vb[8] = 32'h7F800000; ve[8] = 32'hFF800000;
        va[9] = 32'h00800000; vb[9] = 32'h00400000; ve[9] = 32'h00400000;
        va[10] = 32'hBF800000; vb[10] = 32'hBF800000; ve[10] = 32'h00000000;
        for (int i = 0; i < 11; i++) begin
            run_op(va[i], vb[i], res, lat, ok);
            tests++; if (!ok) begin fails++; $display("FAIL directed_valid[%0d]: out_valid never rose", i); end
            tests++; if (res !== ve[i]) begin fails++; $display("FAIL directed[%0d]: %h - %h got %h want %h", i, va[i], vb[i], res, ve[i]); end
            tests++; if (lat != 4) begin fails++; $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res, expv;
        int          lat;
        logic        ok;
        for (int i = 0; i < 300; i++) begin
            rand_pair(x, y);
            expv = ref_sub(x, y);
            run_op(x, y, res, lat, ok);
            tests++; if (!ok || res !== expv) begin fails++; $display("FAIL random[%0d]: %h - %h got %h want %h", i, x, y, res, expv); end
            tests++; if (lat != 4) begin fails++; $display("FAIL random_latency[%0d]: got %0d want 4", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            tests++; if (out_data !== 32'h40000000) begin fails++; $display("FAIL hold_data[%0d]: got %h want 40000000", i, out_data); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL after_hs_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL after_hs_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_midop();
        logic seen;
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL midrst_data: got %h want 00000000", out_data); end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_emitted: got %b want 0", seen); end
        out_ready = 1'b0;
    endtask

    // in_valid and out_ready held high: one accept every 5 edges, results in order.
    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] x, y, w;
        int          last_acc;
        logic        acc, hs;
        last_acc = -1;
        rand_pair(x, y);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_valid & in_ready;
            hs  = out_valid & out_ready;
            @(posedge clk); #1;
            if (hs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra: unexpected result %h", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin fails++; $display("FAIL b2b_data: got %h want %h", out_data, w); end
                end
            end
            if (acc) begin
                exp_q.push_back(ref_sub(a, b));
                if (last_acc >= 0) begin
                    tests++; if (cyc - last_acc != 5) begin fails++; $display("FAIL b2b_spacing: got %0d want 5", cyc - last_acc); end
                end
                last_acc = cyc;
                rand_pair(x, y);
                a = x; b = y;
            end
            if (cyc >= 48) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
